btb_bimodal: RTL
================

Name: btb_bimodal

Overview:
- Parametrised branch target buffer for the fetch stage of the 4-stage pipeline, with a per-entry 2-bit saturating direction counter.
- Lookup is combinational on the fetch PC and returns hit, predicted direction and target in the same cycle.
- Updates arrive from the execute stage once a branch resolves; allocation uses first-free-then-round-robin replacement.
- Supports whole-table flush (fence.i / context change).

Parameters:
- ENTRIES, 8, number of entries; power of 2, range 2..64.
- ADDR_W, 32, PC and target width.
- CNT_W, 2, direction counter width; CNT_W >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- lookup_pc  in  ADDR_W  fetch PC.
- pred_hit  out  1  lookup_pc matches a valid entry.
- pred_taken  out  1  hit and counter MSB = 1.
- pred_target  out  ADDR_W  stored target on hit, else 0.
- upd_valid  in  1  resolved branch update strobe.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual branch direction.
- upd_target  in  ADDR_W  actual branch target (pc+imm computed in execute).
- flush  in  1  invalidate all entries.

Behaviour:
- State per entry: valid, tag (full ADDR_W PC), target, cnt[CNT_W-1:0]. Global state: victim pointer vptr, clog2(ENTRIES) bits.
- Reset (async, rstn=0): all valid=0, tags/targets/cnt=0, vptr=0. Outputs during and after reset: pred_hit=0, pred_taken=0, pred_target=0. Outputs are gated by rstn.

Lookup (combinational, 0 latency):
- Match means valid & tag==lookup_pc.
- Multiple matches cannot occur by construction; if they do, the lowest index wins.
- On miss: pred_taken=0, pred_target=0.

Update (registered, takes effect at the rising edge where upd_valid=1):
- Update hit (upd_pc matches entry k):
  - upd_taken=1: cnt[k] increments, saturating at all-ones; target[k] <= upd_target.
  - upd_taken=0: cnt[k] decrements, saturating at 0; target unchanged.
  - Entry is never invalidated by counter value.
- Update miss with upd_taken=1: allocate.
  - Victim is the lowest-index invalid entry if any; otherwise entry vptr, and vptr <= vptr+1, wrapping at ENTRIES-1 -> 0.
  - vptr advances only when a valid entry is evicted.
  - Allocated entry: valid=1, tag=upd_pc, target=upd_target, cnt = weakly-taken (MSB=1, rest 0; CNT_W=2 gives 2'b10).
- Update miss with upd_taken=0: no change.

Flush:
- Synchronous; clears all valid bits and sets vptr=0. Tags, targets and counters keep stale values but are unobservable.
- flush has priority over a same-cycle upd_valid; that update is dropped.

Timing rules:
- Same-cycle lookup and update of the same PC: lookup returns pre-update contents; new contents are visible from the next cycle.
- upd_valid=0: table holds state.
- Reset asserted mid-operation: immediate clear, no pending update survives.
- Width: counter arithmetic is CNT_W-bit unsigned with explicit saturation, no wrap.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined: adds outputs stat_lookups_hit [31:0] and stat_mispredict [31:0].
  - stat_lookups_hit increments on every cycle with pred_hit=1.
  - stat_mispredict increments on every upd_valid (not suppressed by flush) where the stored prediction disagreed with the outcome. A disagreement is either:
    - hit with counter MSB != upd_taken, or MSB=1 and target != upd_target;
    - miss with upd_taken=1.
  - Both counters saturate at 32'hFFFFFFFF, reset to 0 on rstn, and are unaffected by flush.
- Undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
- Reset then lookup_pc=0x0 -> pred_hit=0, pred_target=0; confirms zeroed tags do not alias PC 0.
- upd pc=0x100 taken target=0x140 -> next cycle lookup 0x100 gives hit=1, taken=1, target=0x140. Same-cycle lookup during that update gives hit=0.
- Four not-taken updates to 0x100 -> cnt 10->01->00->00; pred_taken=0, pred_hit=1. Then two taken updates -> cnt 10, pred_taken=1.
- ENTRIES=8: allocate taken branches at 0x0..0x1C step 4 (fills 0..7), then 0x200 taken -> replaces entry 0, vptr=1; lookup 0x0 misses, 0x200 hits. Next allocation 0x204 replaces entry 1.
- Not-taken update to unseen pc 0x300 -> no allocation, vptr unchanged, lookup 0x300 misses.
- flush and upd_valid (0x400 taken) in the same cycle -> all lookups miss afterwards, 0x400 not allocated. Assert rstn low mid-sequence -> outputs 0 immediately.

Source files
------------

// File: rtl/btb_bimodal.sv
// rtl/btb_bimodal.sv - branch target buffer with per-entry saturating direction counters
// Optional statistics outputs are enabled by defining BTB_STATS_EN.
module btb_bimodal #(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              flush
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]       stat_lookups_hit,
  output logic [31:0]       stat_mispredict
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [CNT_W-1:0]   cnt_d    [ENTRIES];
  logic [IDX_W-1:0]   vptr_q, vptr_d;

  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;
  logic             up_hit;
  logic [IDX_W-1:0] up_idx;
  logic             has_free;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] victim;

  // Match search for lookup and update ports plus lowest free slot; descending scan so the lowest index wins
  always_comb begin
    lk_hit   = 1'b0;
    lk_idx   = '0;
    up_hit   = 1'b0;
    up_idx   = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == lookup_pc)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (valid_q[i] && (tag_q[i] == upd_pc)) begin
        up_hit = 1'b1;
        up_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Predictions are forced to zero while reset is asserted
  assign pred_hit    = rstn & lk_hit;
  assign pred_taken  = pred_hit & cnt_q[lk_idx][CNT_W-1];
  assign pred_target = pred_hit ? target_q[lk_idx] : '0;

  // Next table state: flush beats update; hits train the counter, taken misses allocate
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    vptr_d   = vptr_q;
    victim   = has_free ? free_idx : vptr_q;
    if (flush) begin
      valid_d = '0;
      vptr_d  = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          target_d[up_idx] = upd_target;
          if (cnt_q[up_idx] != CNT_MAX) begin
            cnt_d[up_idx] = cnt_q[up_idx] + CNT_W'(1);
          end
        end else if (cnt_q[up_idx] != '0) begin
          cnt_d[up_idx] = cnt_q[up_idx] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        valid_d[victim]  = 1'b1;
        tag_d[victim]    = upd_pc;
        target_d[victim] = upd_target;
        cnt_d[victim]    = CNT_WEAK;
        if (!has_free) begin
          vptr_d = vptr_q + IDX_W'(1);
        end
      end
    end
  end

  // Table and victim pointer registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      vptr_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      vptr_q   <= vptr_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_hit_q, stat_hit_d;
  logic [31:0] stat_misp_q, stat_misp_d;
  logic        mispredict;

  // Saturating hit and mispredict counters; flush does not affect them
  always_comb begin
    stat_hit_d  = stat_hit_q;
    stat_misp_d = stat_misp_q;
    mispredict  = 1'b0;
    if (up_hit) begin
      mispredict = (cnt_q[up_idx][CNT_W-1] != upd_taken) ||
                   (cnt_q[up_idx][CNT_W-1] && (target_q[up_idx] != upd_target));
    end else begin
      mispredict = upd_taken;
    end
    if (pred_hit && (stat_hit_q != 32'hFFFF_FFFF)) begin
      stat_hit_d = stat_hit_q + 32'd1;
    end
    if (upd_valid && mispredict && (stat_misp_q != 32'hFFFF_FFFF)) begin
      stat_misp_d = stat_misp_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_hit_q  <= '0;
      stat_misp_q <= '0;
    end else begin
      stat_hit_q  <= stat_hit_d;
      stat_misp_q <= stat_misp_d;
    end
  end

  assign stat_lookups_hit = stat_hit_q;
  assign stat_mispredict  = stat_misp_q;
`endif

endmodule
